// File: rtl/piso_register_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out register.
// Optional feature macro: PISO_REGISTER_PARITY_EN (appends an even-parity bit).
package piso_register_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

`ifdef PISO_REGISTER_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Bits per serial frame: the data word, plus the parity bit when enabled.
   function automatic int frame_bits(input int width);
      return width + (PARITY_EN ? 1 : 0);
   endfunction

   // Bit counter width; wide enough that it never wraps inside a frame.
   function automatic int cnt_width(input int width);
      return $clog2(frame_bits(width) + 1);
   endfunction

endpackage

// File: rtl/piso_register_if.sv
// Parallel load handshake plus serial output bus of the PISO register.
interface piso_register_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] data_in;
   logic             ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_last;
   logic             done;

   modport master (
      output load, data_in,
      input  ready, ser_out, ser_valid, ser_last, done
   );

   modport slave (
      input  load, data_in,
      output ready, ser_out, ser_valid, ser_last, done
   );
endinterface

// File: rtl/piso_register.sv
// Parallel-in serial-out register: captures a word on load/ready and shifts it
// out one bit per clock with valid/last qualifiers and a trailing done pulse.
// Optional feature macro: PISO_REGISTER_PARITY_EN (even parity bit after data).
module piso_register
   import piso_register_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   piso_register_if.slave  bus
);

   localparam int FRAME_BITS = frame_bits(WIDTH);
   localparam int CW         = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ser_out_q, ser_out_d;
   logic                  ser_valid_q, ser_valid_d;
   logic                  ser_last_q, ser_last_d;
   logic                  done_q, done_d;
   logic                  ready_q, ready_d;
   logic                  accept_s;
   logic [FRAME_BITS-1:0] frame_s;

`ifdef PISO_REGISTER_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction
`endif

   assign accept_s = (state_q == IDLE) && bus.load;

   // Arrange the incoming word in transmission order (frame_s[0] goes first).
   always_comb begin
      frame_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (LSB_FIRST) begin
            frame_s[i] = bus.data_in[i];
         end else begin
            frame_s[i] = bus.data_in[WIDTH-1-i];
         end
      end
`ifdef PISO_REGISTER_PARITY_EN
      frame_s[FRAME_BITS-1] = even_parity(bus.data_in);
`endif
   end

   // State and output registers; reset has priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   // Next-state logic: accept a word when idle, return after the last bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_q == LAST_CNT) begin
               state_d = IDLE;
            end else begin
               state_d = SHIFT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and next output values; outputs are registered so the serial
   // bit and its qualifiers change together on the clock edge.
   always_comb begin
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      ser_out_d = ser_out_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               ser_out_d = frame_s[0];
               shreg_d   = frame_s >> 1;
               cnt_d     = '0;
            end else begin
               ser_out_d = 1'b0;
               cnt_d     = '0;
            end
         end
         SHIFT: begin
            if (cnt_q == LAST_CNT) begin
               ser_out_d = 1'b0;
               shreg_d   = '0;
               cnt_d     = '0;
               done_d    = 1'b1;
            end else begin
               ser_out_d = shreg_q[0];
               shreg_d   = shreg_q >> 1;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         default: begin
            ser_out_d = 1'b0;
            shreg_d   = '0;
            cnt_d     = '0;
         end
      endcase
      ser_valid_d = (state_d == SHIFT);
      ready_d     = (state_d == IDLE);
      ser_last_d  = (state_d == SHIFT) && (cnt_d == LAST_CNT);
   end

   assign bus.ready     = ready_q;
   assign bus.ser_out   = ser_out_q;
   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_last  = ser_last_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_piso_register.sv
// Directed table-driven bench for piso_register: one LSB-first and one
// MSB-first instance, plus hand-written multi-cycle sequences.
module tb_piso_register;

`ifdef PISO_REGISTER_PARITY_EN
   localparam int FB = 9;
`else
   localparam int FB = 8;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   piso_register_if #(.WIDTH(8)) if_a ();
   piso_register_if #(.WIDTH(8)) if_b ();

   piso_register #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(if_a.slave));
   piso_register #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(if_b.slave));

   // exp_seq[i] is the i-th transmitted data bit; exp_par the parity bit.
   typedef struct {
      logic       msb;
      logic [7:0] din;
      logic [7:0] exp_seq;
      logic       exp_par;
   } vec_t;

   vec_t vecs [7];

   // Observed {ser_valid, ser_out, ser_last, ready, done} of one instance.
   function automatic logic [4:0] obs(input logic msb);
      if (msb) return {if_b.ser_valid, if_b.ser_out, if_b.ser_last, if_b.ready, if_b.done};
      else     return {if_a.ser_valid, if_a.ser_out, if_a.ser_last, if_a.ready, if_a.done};
   endfunction

   task automatic check(input string name, input int idx, input logic msb, input logic [4:0] exp);
      logic [4:0] act;
      act = obs(msb);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] {valid,out,last,ready,done} got=%b want=%b", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic msb, input logic ld, input logic [7:0] d);
      if (msb) begin if_b.load = ld; if_b.data_in = d; end
      else     begin if_a.load = ld; if_a.data_in = d; end
   endtask

   // Present a word and pass the capturing edge; then scramble data_in.
   task automatic start(input logic msb, input logic [7:0] d);
      drive(msb, 1'b1, d);
      @(posedge clk); #1;
      drive(msb, 1'b0, ~d);
   endtask

   // Check every frame bit and the done cycle; at bit mid_at drive mid_ld/mid_d.
   task automatic drain(input string name, input logic msb, input logic [7:0] seq,
                        input logic par, input int mid_at, input logic mid_ld,
                        input logic [7:0] mid_d);
      logic b;
      for (int i = 0; i < FB; i++) begin
         if (i == mid_at) drive(msb, mid_ld, mid_d);
         b = (i < 8) ? seq[i] : par;
         check(name, i, msb, {1'b1, b, (i == FB - 1), 1'b0, 1'b0});
         @(posedge clk); #1;
      end
      check(name, FB, msb, 5'b00010 | 5'b00001);
   endtask

   initial begin
      vecs[0] = '{1'b0, 8'h55, 8'h55, 1'b0};
      vecs[1] = '{1'b0, 8'h07, 8'h07, 1'b1};
      vecs[2] = '{1'b0, 8'h03, 8'h03, 1'b0};
      vecs[3] = '{1'b0, 8'h01, 8'h01, 1'b1};
      vecs[4] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
      vecs[5] = '{1'b1, 8'h0F, 8'hF0, 1'b0};
      vecs[6] = '{1'b1, 8'h07, 8'hE0, 1'b1};

      drive(1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_lsb", 0, 1'b0, 5'b00010);
      check("reset_msb", 0, 1'b1, 5'b00010);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_lsb", 0, 1'b0, 5'b00010);

      // Table-driven frames on both bit orders.
      for (int v = 0; v < 7; v++) begin
         start(vecs[v].msb, vecs[v].din);
         drain("vec", vecs[v].msb, vecs[v].exp_seq, vecs[v].exp_par, FB + 1, 1'b0, 8'h00);
         @(posedge clk); #1;
         check("post_done", v, vecs[v].msb, 5'b00010);
      end

      // Load attempt mid-frame is ignored; word is taken once ready returns.
      start(1'b0, 8'h0F);
      drain("busy_load", 1'b0, 8'h0F, 1'b0, 3, 1'b1, 8'hFF);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00);
      drain("after_busy", 1'b0, 8'hFF, 1'b0, FB + 1, 1'b0, 8'h00);
      @(posedge clk); #1;

      // Load held high: back-to-back frames with one idle (done) cycle between.
      drive(1'b0, 1'b1, 8'h55);
      @(posedge clk); #1;
      drain("held_1", 1'b0, 8'h55, 1'b0, 0, 1'b1, 8'hAA);
      @(posedge clk); #1;
      drain("held_2", 1'b0, 8'hAA, 1'b0, 0, 1'b0, 8'h00);
      @(posedge clk); #1;
      check("held_end", 0, 1'b0, 5'b00010);

      // Reset during bit 4 aborts the frame with no done pulse.
      start(1'b0, 8'hAA);
      for (int i = 0; i < 5; i++) begin
         check("pre_abort", i, 1'b0, {1'b1, (i % 2 == 1), 1'b0, 1'b0, 1'b0});
         if (i < 4) begin @(posedge clk); #1; end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort", 0, 1'b0, 5'b00010);
      @(posedge clk); #1;
      check("abort_nodone", 0, 1'b0, 5'b00010);
      start(1'b0, 8'h01);
      drain("after_abort", 1'b0, 8'h01, 1'b1, FB + 1, 1'b0, 8'h00);
      @(posedge clk); #1;

      // Reset and load on the same edge: the word is not captured.
      rst = 1'b1;
      drive(1'b0, 1'b1, 8'hFF);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      check("rst_load", 0, 1'b0, 5'b00010);
      @(posedge clk); #1;
      check("rst_load_idle", 0, 1'b0, 5'b00010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
